// File: rtl/pong_link_tx_sched_pkg.sv
// pong_link_pkg: shared header bytes, packet sizes, mode decode and FSM states for the game link
package pong_link_pkg;
  localparam logic [7:0] HDR_MASTER_DEF = 8'hA5;
  localparam logic [7:0] HDR_SLAVE_DEF  = 8'h5A;
  localparam int unsigned N_MASTER_CHK   = 8;
  localparam int unsigned N_MASTER_NOCHK = 7;
  localparam int unsigned N_SLAVE_CHK    = 4;
  localparam int unsigned N_SLAVE_NOCHK  = 3;
  typedef enum logic [1:0] {MODE_MASTER, MODE_SLAVE, MODE_SINGLE} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_e;
  function automatic mode_e decode_mode(input logic [2:1] sw);
    return sw[2] ? MODE_SLAVE : (sw[1] ? MODE_SINGLE : MODE_MASTER);
  endfunction
endpackage

// File: rtl/pong_link_tx_sched_if.sv
// pong_link_tx_sched_if: byte valid/ready handshake towards the UART transmitter
interface pong_link_tx_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/pong_link_tx_sched.sv
// pong_link_tx_sched: per-frame game state snapshot serialized as a byte packet to the UART TX.
// PONG_LINK_CHECKSUM_EN appends an XOR checksum byte over the payload.
module pong_link_tx_sched
  import pong_link_pkg::*;
#(
  parameter logic [7:0] HDR_MASTER = HDR_MASTER_DEF,
  parameter logic [7:0] HDR_SLAVE  = HDR_SLAVE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic [2:1]                  sw,
  input  logic [10:0]                 x_ball,
  input  logic [9:0]                  y_ball,
  input  logic [9:0]                  y_paddle,
  pong_link_tx_sched_if.master        tx,
  output logic                        busy,
  output logic                        frame_sent,
  output logic                        overrun
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SEND = ST_SEND;
  localparam logic [1:0] DONE = ST_DONE;
`ifdef PONG_LINK_CHECKSUM_EN
  localparam logic [2:0] LAST_M = 3'(N_MASTER_CHK - 1);
  localparam logic [2:0] LAST_S = 3'(N_SLAVE_CHK - 1);
`else
  localparam logic [2:0] LAST_M = 3'(N_MASTER_NOCHK - 1);
  localparam logic [2:0] LAST_S = 3'(N_SLAVE_NOCHK - 1);
`endif
  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d, idx_n;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d, p_q, p_d;
  logic        slave_q, slave_d;
  logic [7:0]  data_q, data_d, nxt_byte, chk_nxt;
  logic        valid_q, valid_d, busy_q, busy_d, sent_q, sent_d, ovr_q, ovr_d;
  logic        accept, last, start;
  mode_e       mode;
  assign mode   = decode_mode(sw);
  assign accept = valid_q && tx.tx_ready;
  assign last   = idx_q == (slave_q ? LAST_S : LAST_M);
  assign start  = state_q == IDLE && frame_tick && mode != MODE_SINGLE;
  assign idx_n  = idx_q + 3'd1;
`ifdef PONG_LINK_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  // the byte being accepted now is folded in so the checksum is ready as the very next byte
  assign chk_nxt = chk_q ^ (idx_q != 3'd0 ? data_q : 8'h00);
  assign chk_d   = start ? 8'h00 : (accept ? chk_nxt : chk_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) chk_q <= 8'h00;
    else     chk_q <= chk_d;
`else
  assign chk_nxt = 8'h00;
`endif
  always_comb begin
    nxt_byte = chk_nxt;
    if (slave_q)
      case (idx_n)
        3'd1:    nxt_byte = {6'b0, p_q[9:8]};
        3'd2:    nxt_byte = p_q[7:0];
        default: nxt_byte = chk_nxt;
      endcase
    else
      case (idx_n)
        3'd1:    nxt_byte = {5'b0, x_q[10:8]};
        3'd2:    nxt_byte = x_q[7:0];
        3'd3:    nxt_byte = {6'b0, y_q[9:8]};
        3'd4:    nxt_byte = y_q[7:0];
        3'd5:    nxt_byte = {6'b0, p_q[9:8]};
        3'd6:    nxt_byte = p_q[7:0];
        default: nxt_byte = chk_nxt;
      endcase
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    slave_d = slave_q;
    data_d  = data_q;
    valid_d = valid_q;
    sent_d  = 1'b0;
    ovr_d   = frame_tick && state_q != IDLE;
    if (start) begin
      state_d = SEND;
      idx_d   = 3'd0;
      x_d     = x_ball;
      y_d     = y_ball;
      p_d     = y_paddle;
      slave_d = mode == MODE_SLAVE;
      data_d  = mode == MODE_SLAVE ? HDR_SLAVE : HDR_MASTER;
      valid_d = 1'b1;
    end else if (state_q == SEND && accept) begin
      state_d = last ? DONE : SEND;
      valid_d = !last;
      sent_d  = last;
      idx_d   = last ? idx_q : idx_n;
      data_d  = last ? data_q : nxt_byte;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      slave_q <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      slave_q <= slave_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      ovr_q   <= ovr_d;
    end
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = busy_q;
  assign frame_sent  = sent_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_pong_link_tx_sched.sv
// tb_pong_link_tx_sched: scoreboard bench for the link transmit scheduler
module tb_pong_link_tx_sched;
`ifdef PONG_LINK_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NM = CHK ? 8 : 7;
  localparam int NS = CHK ? 4 : 3;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0;
  logic [2:1] sw = 2'b00;
  logic [10:0] x_ball = '0;
  logic [9:0] y_ball = '0, y_paddle = '0;
  logic busy, frame_sent, overrun;
  logic [7:0] exp_b;
  logic [7:0] sb[$];
  int total = 0, bad = 0;
  pong_link_tx_sched_if tx();
  pong_link_tx_sched dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .sw(sw),
    .x_ball(x_ball), .y_ball(y_ball), .y_paddle(y_paddle),
    .tx(tx), .busy(busy), .frame_sent(frame_sent), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && tx.tx_valid && tx.tx_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL byte_unexpected got=%02h want=none", tx.tx_data);
      end else begin
        exp_b = sb.pop_front();
        if (tx.tx_data !== exp_b) begin
          bad++;
          $display("FAIL byte got=%02h want=%02h", tx.tx_data, exp_b);
        end
      end
    end
  task automatic push_pkt(input bit slave, input logic [10:0] x, input logic [9:0] y, input logic [9:0] p);
    logic [7:0] b[$];
    logic [7:0] c = 8'h00;
    if (slave) b = '{8'h5A, {6'b0, p[9:8]}, p[7:0]};
    else b = '{8'hA5, {5'b0, x[10:8]}, x[7:0], {6'b0, y[9:8]}, y[7:0], {6'b0, p[9:8]}, p[7:0]};
    for (int i = 1; i < b.size(); i++) c ^= b[i];
    if (CHK) b.push_back(c);
    foreach (b[i]) sb.push_back(b[i]);
  endtask
  task automatic tick(input logic [2:1] s, input logic [10:0] x, input logic [9:0] y, input logic [9:0] p, input bit push);
    @(posedge clk); #1;
    sw = s; x_ball = x; y_ball = y; y_paddle = p; frame_tick = 1'b1;
    if (push) push_pkt(s[2], x, y, p);
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask
  task automatic test_reset();
    tx.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", tx.tx_valid); end
    total++; if (tx.tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%02h want=00", tx.tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (frame_sent !== 1'b0) begin bad++; $display("FAIL rst_sent got=%b want=0", frame_sent); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", overrun); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_packet(input logic [2:1] s, input logic [10:0] x, input logic [9:0] y, input logic [9:0] p, input int n);
    tx.tx_ready = 1'b1;
    tick(s, x, y, p, 1'b1);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      total++;
      if (frame_sent !== 1'(k == n + 1)) begin bad++; $display("FAIL sent_k%0d got=%b want=%b", k, frame_sent, k == n + 1); end
      total++;
      if (busy !== 1'(k <= n + 1)) begin bad++; $display("FAIL busy_k%0d got=%b want=%b", k, busy, k <= n + 1); end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL pkt_left got=%0d want=0", sb.size()); end
  endtask
  task automatic test_single();
    tx.tx_ready = 1'b1;
    tick(2'b01, 11'h123, 10'h045, 10'h067, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (tx.tx_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL single_k%0d got=v%b o%b b%b want=000", k, tx.tx_valid, overrun, busy);
      end
    end
    sw = 2'b00;
  endtask
  task automatic test_backpressure();
    logic hold = 1'b0, done = 1'b0;
    logic [7:0] prev = 8'h00;
    tx.tx_ready = 1'b1;
    tick(2'b00, 11'h3AB, 10'h2CD, 10'h155, 1'b1);
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      tx.tx_ready = (k % 3 == 2);
      sw = 2'($urandom); x_ball = 11'($urandom); y_ball = 10'($urandom); y_paddle = 10'($urandom);
      @(negedge clk);
      if (hold) begin
        total++;
        if (tx.tx_data !== prev) begin bad++; $display("FAIL hold got=%02h want=%02h", tx.tx_data, prev); end
      end
      hold = tx.tx_valid && !tx.tx_ready;
      prev = tx.tx_data;
      done = frame_sent;
    end
    total++; if (!done) begin bad++; $display("FAIL bp_timeout got=0 want=1"); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_left got=%0d want=0", sb.size()); end
    tx.tx_ready = 1'b1; sw = 2'b00;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_overrun();
    int pulses = 0;
    tx.tx_ready = 1'b1;
    tick(2'b00, 11'h0F1, 10'h2E3, 10'h1D5, 1'b1);
    for (int k = 1; k <= NM + 4; k++) begin
      @(posedge clk); #1;
      frame_tick = (k == 2);
      @(negedge clk);
      if (overrun) pulses++;
      total++;
      if (overrun !== 1'(k == 3)) begin bad++; $display("FAIL ovr_k%0d got=%b want=%b", k, overrun, k == 3); end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", pulses); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL ovr_left got=%0d want=0", sb.size()); end
  endtask
  task automatic test_reset_mid();
    logic done = 1'b0;
    tx.tx_ready = 1'b1;
    tick(2'b00, 11'h7FF, 10'h3FF, 10'h2AA, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (tx.tx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", tx.tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2'b00, 11'h0AB, 10'h155, 10'h2F0, 1'b1);
    @(negedge clk);
    total++; if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'hA5) begin bad++; $display("FAIL rstmid_hdr got=v%b %02h want=v1 a5", tx.tx_valid, tx.tx_data); end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = frame_sent;
    end
    total++; if (!done) begin bad++; $display("FAIL rstmid_timeout got=0 want=1"); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rstmid_left got=%0d want=0", sb.size()); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_packet(2'b00, 11'h190, 10'h12C, 10'h0F0, NM);
    test_packet(2'b10, 11'h000, 10'h000, 10'h1F4, NS);
    test_single();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
